// File: rtl/sl_pkg.sv
// Shared definitions for the SL serial line receiver: register map,
// STATUS bit positions and the decoder state encoding.
package sl_pkg;

    // Register byte addresses on the APB side
    localparam logic [7:0] SL_CTRL_ADDR   = 8'h00;
    localparam logic [7:0] SL_STATUS_ADDR = 8'h04;
    localparam logic [7:0] SL_DATA_ADDR   = 8'h08;

    // CTRL bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CLEAR  = 1;

    // STATUS bit positions
    localparam int ST_READY      = 0;
    localparam int ST_PARITY_ERR = 1;
    localparam int ST_LEN_ERR    = 2;
    localparam int ST_PULSE_ERR  = 3;
    localparam int ST_NOISE      = 4;
    localparam int ST_OVERRUN    = 5;
    localparam int ST_COUNT_LSB  = 8;
    localparam int ST_COUNT_W    = 6;

    // Line decoder states
    typedef enum logic [1:0] {
        DEC_IDLE  = 2'd0,
        DEC_PULSE = 2'd1,
        DEC_STOP  = 2'd2
    } dec_state_e;

endpackage

// File: rtl/sl_rx_decoder.sv
// SL line decoder: 2-FF synchronizers, low-pulse width counter, state
// machine and bit shift register. Emits a one-cycle commit strobe with
// the assembled word and single-cycle noise / pulse-error events.
// Parity checking is compiled in only when SL_PARITY_CHECK_EN is defined.
module sl_rx_decoder
    import sl_pkg::*;
#(
    parameter int MIN_PULSE = 8,
    parameter int MAX_PULSE = 24,
    parameter int DATA_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sl0,
    input  logic                  sl1,
    input  logic                  enable,
    input  logic                  abort,
    output logic                  commit,
    output logic [DATA_W-1:0]     commit_data,
    output logic [ST_COUNT_W-1:0] commit_count,
    output logic                  commit_par_err,
    output logic                  commit_len_err,
    output logic                  noise_evt,
    output logic                  pulse_err_evt
);

    localparam int CNT_W = $clog2(MAX_PULSE + 2);
    localparam int SH_W  = DATA_W + 1;
    localparam int BC_W  = $clog2(DATA_W + 3);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_PULSE + 1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PULSE);
    localparam logic [BC_W-1:0]  BC_SAT  = BC_W'(DATA_W + 2);
    localparam logic [BC_W-1:0]  BC_MAXW = BC_W'(DATA_W + 1);

    logic [1:0]       sl0_sync_q, sl1_sync_q;
    logic             s0, s1;
    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             line_q, line_d;
    logic [SH_W-1:0]  shift_q, shift_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]  ndata;
    logic             ones_odd;
    logic             both_high, both_low, tracked_low;

    assign s0 = sl0_sync_q[1];
    assign s1 = sl1_sync_q[1];

    // Two-stage synchronizers; lines idle high so reset to 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sl0_sync_q <= 2'b11;
            sl1_sync_q <= 2'b11;
        end else begin
            sl0_sync_q <= {sl0_sync_q[0], sl0};
            sl1_sync_q <= {sl1_sync_q[0], sl1};
        end
    end

    // Decoder state, pulse counter and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DEC_IDLE;
            cnt_q     <= '0;
            line_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic: pulse classification, bit capture and stop handling
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        line_d        = line_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        commit        = 1'b0;
        noise_evt     = 1'b0;
        pulse_err_evt = 1'b0;

        both_high   = s0 && s1;
        both_low    = !s0 && !s1;
        tracked_low = line_q ? !s1 : !s0;
        cnt_inc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

        if (!enable || abort) begin
            state_d   = DEC_IDLE;
            cnt_d     = '0;
            shift_d   = '0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                DEC_IDLE: begin
                    if (both_low) begin
                        state_d = DEC_STOP;
                        cnt_d   = CNT_W'(1);
                    end else if (!s0 || !s1) begin
                        state_d = DEC_PULSE;
                        line_d  = !s1;
                        cnt_d   = CNT_W'(1);
                    end
                end
                DEC_PULSE: begin
                    if (tracked_low) begin
                        if (both_low) begin
                            // Second line joined: this is the start of a stop symbol
                            state_d = DEC_STOP;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        if (cnt_q < CNT_MIN) begin
                            noise_evt = 1'b1;
                        end else if (cnt_q > CNT_MAX) begin
                            pulse_err_evt = 1'b1;
                        end else begin
                            for (int i = 0; i < SH_W; i++) begin
                                if (BC_W'(i) == bit_cnt_q) shift_d[i] = line_q;
                            end
                            if (bit_cnt_q != BC_SAT) bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                        if (both_high) begin
                            state_d = DEC_IDLE;
                            cnt_d   = '0;
                        end else begin
                            // Other line went low on the same cycle: new pulse
                            state_d = DEC_PULSE;
                            line_d  = !line_q;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEC_STOP: begin
                    if (both_high) begin
                        if (cnt_q >= CNT_MIN) begin
                            commit    = 1'b1;
                            shift_d   = '0;
                            bit_cnt_d = '0;
                        end else begin
                            noise_evt = 1'b1;
                        end
                        state_d = DEC_IDLE;
                        cnt_d   = '0;
                    end else if (both_low) begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = DEC_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Word assembly: strip the parity bit, right-align data, check parity/length
    always_comb begin
        ndata    = (bit_cnt_q == '0) ? '0 : bit_cnt_q - BC_W'(1);
        ones_odd = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            commit_data[i] = (BC_W'(i) < ndata) && shift_q[i];
        end
        for (int i = 0; i < SH_W; i++) begin
            if (BC_W'(i) < bit_cnt_q) ones_odd = ones_odd ^ shift_q[i];
        end
        commit_count   = ST_COUNT_W'(ndata);
        commit_len_err = (bit_cnt_q < BC_W'(2)) || (bit_cnt_q > BC_MAXW);
`ifdef SL_PARITY_CHECK_EN
        commit_par_err = !ones_odd;
`else
        commit_par_err = 1'b0;
`endif
    end

endmodule

// File: rtl/sl_transceiver.sv
// SL serial line receiver top: APB-style register block (CTRL, STATUS,
// DATA) around the sl_rx_decoder line decoder. Parity reporting depends
// on the SL_PARITY_CHECK_EN macro (see sl_rx_decoder).
module sl_transceiver
    import sl_pkg::*;
#(
    parameter int MIN_PULSE = 8,
    parameter int MAX_PULSE = 24,
    parameter int DATA_W    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sl0,
    input  logic       sl1,
    input  logic [7:0] paddr,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    inout  wire [31:0] pdata
);

    logic                  enable_q, enable_d;
    logic                  ready_q, ready_d;
    logic                  parity_err_q, parity_err_d;
    logic                  len_err_q, len_err_d;
    logic                  pulse_err_q, pulse_err_d;
    logic                  noise_q, noise_d;
    logic                  overrun_q, overrun_d;
    logic [ST_COUNT_W-1:0] count_q, count_d;
    logic [DATA_W-1:0]     data_q, data_d;

    logic                  commit;
    logic [DATA_W-1:0]     commit_data;
    logic [ST_COUNT_W-1:0] commit_count;
    logic                  commit_par_err, commit_len_err;
    logic                  noise_evt, pulse_err_evt;

    logic                  wr_ctrl, abort, rd_data_clr;
    logic [31:0]           rdata;
    logic                  unused_wdata;

    assign wr_ctrl      = psel && penable && pwrite && (paddr == SL_CTRL_ADDR);
    assign abort        = wr_ctrl && pdata[CTRL_CLEAR];
    assign rd_data_clr  = psel && penable && !pwrite && (paddr == SL_DATA_ADDR);
    assign unused_wdata = ^pdata[31:2];

    sl_rx_decoder #(
        .MIN_PULSE(MIN_PULSE),
        .MAX_PULSE(MAX_PULSE),
        .DATA_W   (DATA_W)
    ) u_dec (
        .clk           (clk),
        .reset         (reset),
        .sl0           (sl0),
        .sl1           (sl1),
        .enable        (enable_q),
        .abort         (abort),
        .commit        (commit),
        .commit_data   (commit_data),
        .commit_count  (commit_count),
        .commit_par_err(commit_par_err),
        .commit_len_err(commit_len_err),
        .noise_evt     (noise_evt),
        .pulse_err_evt (pulse_err_evt)
    );

    // Register file state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q     <= 1'b1;
            ready_q      <= 1'b0;
            parity_err_q <= 1'b0;
            len_err_q    <= 1'b0;
            pulse_err_q  <= 1'b0;
            noise_q      <= 1'b0;
            overrun_q    <= 1'b0;
            count_q      <= '0;
            data_q       <= '0;
        end else begin
            enable_q     <= enable_d;
            ready_q      <= ready_d;
            parity_err_q <= parity_err_d;
            len_err_q    <= len_err_d;
            pulse_err_q  <= pulse_err_d;
            noise_q      <= noise_d;
            overrun_q    <= overrun_d;
            count_q      <= count_d;
            data_q       <= data_d;
        end
    end

    // Register updates: CTRL write, sticky events, DATA read-clear, then commit (commit wins)
    always_comb begin
        enable_d     = enable_q;
        ready_d      = ready_q;
        parity_err_d = parity_err_q;
        len_err_d    = len_err_q;
        pulse_err_d  = pulse_err_q;
        noise_d      = noise_q;
        overrun_d    = overrun_q;
        count_d      = count_q;
        data_d       = data_q;

        if (wr_ctrl) enable_d = pdata[CTRL_ENABLE];
        if (noise_evt) noise_d = 1'b1;
        if (pulse_err_evt) pulse_err_d = 1'b1;

        if (rd_data_clr) begin
            ready_d      = 1'b0;
            parity_err_d = 1'b0;
            len_err_d    = 1'b0;
            pulse_err_d  = 1'b0;
            noise_d      = 1'b0;
            overrun_d    = 1'b0;
        end

        if (commit) begin
            if (ready_q && !rd_data_clr) overrun_d = 1'b1;
            ready_d      = 1'b1;
            data_d       = commit_data;
            count_d      = commit_count;
            parity_err_d = commit_par_err;
            len_err_d    = commit_len_err;
        end
    end

    // Read mux, valid in both setup and access phases
    always_comb begin
        rdata = '0;
        case (paddr)
            SL_CTRL_ADDR: rdata[CTRL_ENABLE] = enable_q;
            SL_STATUS_ADDR: begin
                rdata[ST_READY]                       = ready_q;
                rdata[ST_PARITY_ERR]                  = parity_err_q;
                rdata[ST_LEN_ERR]                     = len_err_q;
                rdata[ST_PULSE_ERR]                   = pulse_err_q;
                rdata[ST_NOISE]                       = noise_q;
                rdata[ST_OVERRUN]                     = overrun_q;
                rdata[ST_COUNT_LSB +: ST_COUNT_W]     = count_q;
            end
            SL_DATA_ADDR: rdata = 32'(data_q);
            default: rdata = '0;
        endcase
    end

    assign pdata = (psel && !pwrite) ? rdata : 32'bz;

endmodule

// File: tb/tb_sl_transceiver.sv
// Directed bench for sl_transceiver: drives SL words on the line pair and
// checks CTRL/STATUS/DATA over the APB-style bus.
module tb_sl_transceiver;
    import sl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sl0, sl1;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pdata_drv;
    logic        pdata_oe;
    wire  [31:0] pdata;
    logic [31:0] rd;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SL_PARITY_CHECK_EN
    localparam logic [31:0] PE = 32'h2;
`else
    localparam logic [31:0] PE = 32'h0;
`endif

    assign pdata = pdata_oe ? pdata_drv : 32'bz;

    sl_transceiver dut (
        .clk    (clk),
        .reset  (reset),
        .sl0    (sl0),
        .sl1    (sl1),
        .paddr  (paddr),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .pdata  (pdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic line, input int width, input int gap = 4);
        if (line) sl1 = 1'b0; else sl0 = 1'b0;
        idle(width);
        sl0 = 1'b1;
        sl1 = 1'b1;
        idle(gap);
    endtask

    task automatic stop(input int width);
        sl0 = 1'b0;
        sl1 = 1'b0;
        idle(width);
        sl0 = 1'b1;
        sl1 = 1'b1;
        idle(8);
    endtask

    function automatic logic odd_par(input logic [31:0] v);
        return ~(^v);
    endfunction

    task automatic send_word(input logic [31:0] val, input int nbits, input logic flip);
        for (int i = 0; i < nbits; i++) pulse(val[i], 16);
        pulse(odd_par(val) ^ flip, 16);
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
        psel    = 1'b1;
        pwrite  = 1'b0;
        paddr   = addr;
        idle(1);
        penable = 1'b1;
        #1;
        data = pdata;
        idle(1);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        psel      = 1'b1;
        pwrite    = 1'b1;
        paddr     = addr;
        pdata_oe  = 1'b1;
        pdata_drv = data;
        idle(1);
        penable = 1'b1;
        idle(1);
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        pdata_oe = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        apb_read(addr, v);
        check(tag, v, exp);
    endtask

    initial begin
        reset = 1'b1; sl0 = 1'b1; sl1 = 1'b1;
        paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pdata_oe = 1'b0; pdata_drv = '0;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Reset state
        check_reg("rst_ctrl",   SL_CTRL_ADDR,   32'h1);
        check_reg("rst_status", SL_STATUS_ADDR, 32'h0);
        check_reg("rst_data",   SL_DATA_ADDR,   32'h0);
        check_reg("unmapped",   8'h0C,          32'h0);

        // Good 16-bit word
        send_word(32'hA5C3, 16, 1'b0);
        stop(12);
        check_reg("w1_status",  SL_STATUS_ADDR, 32'h1001);
        check_reg("w1_data",    SL_DATA_ADDR,   32'h0000A5C3);
        check_reg("w1_status2", SL_STATUS_ADDR, 32'h1000);

        // Wrong parity line
        send_word(32'hA5C3, 16, 1'b1);
        stop(12);
        check_reg("par_status",  SL_STATUS_ADDR, 32'h1001 | PE);
        check_reg("par_data",    SL_DATA_ADDR,   32'h0000A5C3);
        check_reg("par_status2", SL_STATUS_ADDR, 32'h1000);

        // Glitches between bits
        for (int i = 0; i < 16; i++) begin
            pulse(rd[0] | ((32'h1234 >> i) & 1) != 0, 16);
            if (i == 3) pulse(1'b0, 1);
            if (i == 7) pulse(1'b0, 4);
        end
        pulse(odd_par(32'h1234), 16);
        stop(12);
        check_reg("gl_status", SL_STATUS_ADDR, 32'h1011);
        check_reg("gl_data",   SL_DATA_ADDR,   32'h1234);

        // Over-long pulse inside a word
        for (int i = 0; i < 8; i++) begin
            pulse(((32'h5A >> i) & 1) != 0, 16);
            if (i == 2) pulse(1'b1, 30);
        end
        pulse(odd_par(32'h5A), 16);
        stop(12);
        check_reg("pe_status", SL_STATUS_ADDR, 32'h0809);
        check_reg("pe_data",   SL_DATA_ADDR,   32'h5A);

        // Pulse width limits: MIN and MAX are valid
        pulse(1'b1, 8);
        pulse(1'b0, 24);
        pulse(1'b0, 16);
        stop(12);
        check_reg("lim_status", SL_STATUS_ADDR, 32'h0201);
        check_reg("lim_data",   SL_DATA_ADDR,   32'h1);

        // Too-short stop is noise, next stop commits
        send_word(32'h5A, 8, 1'b0);
        stop(7);
        stop(8);
        check_reg("ss_status", SL_STATUS_ADDR, 32'h0811);
        check_reg("ss_data",   SL_DATA_ADDR,   32'h5A);

        // Single-bit word: length error
        pulse(1'b1, 16);
        stop(12);
        check_reg("len_status", SL_STATUS_ADDR, 32'h0005);
        check_reg("len_data",   SL_DATA_ADDR,   32'h0);

        // Overrun
        send_word(32'h5A, 8, 1'b0);
        stop(12);
        send_word(32'h3C, 8, 1'b0);
        stop(12);
        check_reg("ov_status",  SL_STATUS_ADDR, 32'h0821);
        check_reg("ov_data",    SL_DATA_ADDR,   32'h3C);
        check_reg("ov_status2", SL_STATUS_ADDR, 32'h0800);

        // Clear aborts a partial word
        pulse(1'b1, 16);
        pulse(1'b1, 16);
        pulse(1'b1, 16);
        apb_write(SL_CTRL_ADDR, 32'h3);
        send_word(32'h5A, 8, 1'b0);
        stop(12);
        check_reg("clr_status", SL_STATUS_ADDR, 32'h0801);
        check_reg("clr_data",   SL_DATA_ADDR,   32'h5A);
        check_reg("clr_ctrl",   SL_CTRL_ADDR,   32'h1);

        // Disabled decoder ignores the lines
        apb_write(SL_CTRL_ADDR, 32'h0);
        check_reg("dis_ctrl", SL_CTRL_ADDR, 32'h0);
        send_word(32'h3C, 8, 1'b0);
        stop(12);
        check_reg("dis_status", SL_STATUS_ADDR, 32'h0800);
        check_reg("dis_data",   SL_DATA_ADDR,   32'h5A);
        apb_write(SL_CTRL_ADDR, 32'h1);

        // Reset mid-word, then a full word
        for (int i = 0; i < 5; i++) pulse(1'b1, 16);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);
        check_reg("mr_status", SL_STATUS_ADDR, 32'h0);
        check_reg("mr_ctrl",   SL_CTRL_ADDR,   32'h1);
        check_reg("mr_data",   SL_DATA_ADDR,   32'h0);
        send_word(32'h5A, 8, 1'b0);
        stop(12);
        check_reg("mr_w_status", SL_STATUS_ADDR, 32'h0801);
        check_reg("mr_w_data",   SL_DATA_ADDR,   32'h5A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
